// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_sequencer_if                                            |
// | Description : Fetch-side valid/ready bus between the PC sequencer and    |
// |               the instruction cache.                                     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface pc_sequencer_if #(
  parameter int SIZE = 64
);
  logic            pc_valid;
  logic            pc_ready;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] pc_next_seq;

  modport master (
    output pc_valid,
    output pc,
    output pc_next_seq,
    input  pc_ready
  );

  modport slave (
    input  pc_valid,
    input  pc,
    input  pc_next_seq,
    output pc_ready
  );
endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_sequencer                                               |
// | Description : Registered MIPS64 fetch PC with stall-aware advance and    |
// |               branch/exception redirect. PC_ALIGN_CHECK_EN turns a       |
// |               misaligned branch target into an exception redirect.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int          SIZE         = 64,
  parameter logic [63:0] STEP         = 64'd4,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_BFC0_0000,
  parameter logic [63:0] EXC_VECTOR   = 64'hFFFF_FFFF_BFC0_0380
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            halt_i,
  input  wire logic            br_valid_i,
  input  wire logic [SIZE-1:0] br_target_i,
  input  wire logic            exc_req_i,
  pc_sequencer_if.master       fetch,
  output logic      [SIZE-1:0] epc_o,
  output logic                 exc_misalign_o
);

  localparam logic [SIZE-1:0] c_step       = STEP[SIZE-1:0];
  localparam logic [SIZE-1:0] c_reset_vec  = RESET_VECTOR[SIZE-1:0];
  localparam logic [SIZE-1:0] c_exc_vec    = EXC_VECTOR[SIZE-1:0];
  // STEP is a power of two, so STEP-1 selects exactly the low log2(STEP) bits.
  localparam logic [SIZE-1:0] c_align_mask = c_step - SIZE'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] epc_q, epc_d;
  logic            misalign_d;
  logic [SIZE-1:0] w_br_aligned;

  assign w_br_aligned = br_target_i & ~c_align_mask;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic w_br_misalign;

  assign w_br_misalign  = |(br_target_i & c_align_mask);
  assign exc_misalign_o = misalign_q;
`else
  assign exc_misalign_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (exc_req_i) begin
          pc_d  = c_exc_vec;
          epc_d = pc_q;
        end else if (br_valid_i) begin
`ifdef PC_ALIGN_CHECK_EN
          if (w_br_misalign) begin
            pc_d       = c_exc_vec;
            epc_d      = br_target_i;
            misalign_d = 1'b1;
          end else begin
            pc_d = br_target_i;
          end
`else
          pc_d = w_br_aligned;
`endif
        end else if (fetch.pc_ready) begin
          pc_d = pc_q + c_step;
        end
        if (halt_i) state_d = ST_HALT;
      end
      ST_HALT: begin
        // Exceptions must still be taken while halted; branches are not.
        if (exc_req_i) begin
          pc_d    = c_exc_vec;
          epc_d   = pc_q;
          state_d = ST_RUN;
        end else if (!halt_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= c_reset_vec;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  logic w_unused;
  assign w_unused = misalign_d;
`endif

  assign fetch.pc_valid    = (state_q == ST_RUN);
  assign fetch.pc          = pc_q;
  assign fetch.pc_next_seq = pc_q + c_step;
  assign epc_o             = epc_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                            |
// | Description : Self-checking bench for pc_sequencer with a behavioural    |
// |               PC model; honours PC_ALIGN_CHECK_EN.                       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int          SIZE  = 64;
  localparam logic [63:0] STEP  = 64'd4;
  localparam logic [63:0] RST_V = 64'hFFFF_FFFF_BFC0_0000;
  localparam logic [63:0] EXC_V = 64'hFFFF_FFFF_BFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halt = 1'b0;
  logic        br_valid = 1'b0;
  logic        exc_req = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] epc;
  logic        exc_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer_if #(.SIZE(SIZE)) fif ();

  pc_sequencer #(
    .SIZE(SIZE), .STEP(STEP), .RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt_i(halt), .br_valid_i(br_valid),
    .br_target_i(br_target), .exc_req_i(exc_req), .fetch(fif.master),
    .epc_o(epc), .exc_misalign_o(exc_misalign)
  );

  always #5 clk = ~clk;

  // Behavioural model: "booting" and "halted" flags plus architectural values.
  logic [63:0] m_pc, m_epc;
  bit          m_boot, m_halt, m_mis;

  task automatic model_reset();
    m_pc = RST_V; m_epc = '0; m_boot = 1; m_halt = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    logic [63:0] old_pc;
    old_pc = m_pc;
    m_mis  = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt) begin
      if (exc_req) begin
        m_pc = EXC_V; m_epc = old_pc;
      end else if (br_valid) begin
        if (br_target % STEP != 0) begin
`ifdef PC_ALIGN_CHECK_EN
          m_pc = EXC_V; m_epc = br_target; m_mis = 1;
`else
          m_pc = br_target - (br_target % STEP);
`endif
        end else begin
          m_pc = br_target;
        end
      end else if (fif.pc_ready) begin
        m_pc = old_pc + STEP;
      end
      if (halt) m_halt = 1;
    end else begin
      if (exc_req) begin
        m_pc = EXC_V; m_epc = old_pc; m_halt = 0;
      end else if (!halt) begin
        m_halt = 0;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    halt = 0; br_valid = 0; exc_req = 0; br_target = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; fif.pc_ready = 1; clear_inputs();
    model_reset();
    @(posedge clk); #1;
    n_checks++; if (fif.pc !== RST_V) $display("FAIL reset_pc got=%h exp=%h", fif.pc, RST_V); else n_pass++;
    n_checks++; if (epc !== 64'd0) $display("FAIL reset_epc got=%h exp=0", epc); else n_pass++;
    n_checks++; if (fif.pc_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fif.pc_valid); else n_pass++;
    n_checks++; if (exc_misalign !== 1'b0) $display("FAIL reset_mis got=%b exp=0", exc_misalign); else n_pass++;
    n_checks++; if (fif.pc_next_seq !== RST_V + 64'd4) $display("FAIL reset_nseq got=%h exp=%h", fif.pc_next_seq, RST_V + 64'd4); else n_pass++;
    rst_n = 1;
    n_checks++; if (fif.pc_valid !== 1'b0) $display("FAIL boot_valid got=%b exp=0", fif.pc_valid); else n_pass++;
    cycle();
    n_checks++; if (fif.pc_valid !== 1'b1 || fif.pc !== RST_V) $display("FAIL first_fetch valid=%b pc=%h exp 1/%h", fif.pc_valid, fif.pc, RST_V); else n_pass++;
    repeat (3) cycle();
    n_checks++; if (fif.pc !== RST_V + 64'd12) $display("FAIL three_accepts got=%h exp=%h", fif.pc, RST_V + 64'd12); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    held = fif.pc;
    fif.pc_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++; if (fif.pc !== held || fif.pc_valid !== 1'b1) $display("FAIL stall_hold[%0d] pc=%h valid=%b exp %h/1", i, fif.pc, fif.pc_valid, held); else n_pass++;
    end
    fif.pc_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_checks++; if (fif.pc !== held + 64'(4 * i)) $display("FAIL stall_release[%0d] got=%h exp=%h", i, fif.pc, held + 64'(4 * i)); else n_pass++;
    end
  endtask

  task automatic test_branch_vs_exc();
    br_valid = 1; br_target = 64'h2000;
    cycle();
    n_checks++; if (fif.pc !== 64'h2000) $display("FAIL br_to_2000 got=%h exp=2000", fif.pc); else n_pass++;
    exc_req = 1; br_target = 64'h1000;
    cycle();
    n_checks++; if (fif.pc !== EXC_V || epc !== 64'h2000) $display("FAIL exc_wins pc=%h epc=%h exp %h/2000", fif.pc, epc, EXC_V); else n_pass++;
    exc_req = 0;
    cycle();
    n_checks++; if (fif.pc !== 64'h1000 || fif.pc_valid !== 1'b1) $display("FAIL br_alone pc=%h valid=%b exp 1000/1", fif.pc, fif.pc_valid); else n_pass++;
    br_valid = 0;
  endtask

  task automatic test_wrap();
    br_valid = 1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    br_valid = 0;
    cycle();
    n_checks++; if (fif.pc !== 64'd0 || exc_misalign !== 1'b0) $display("FAIL wrap pc=%h mis=%b exp 0/0", fif.pc, exc_misalign); else n_pass++;
  endtask

  task automatic test_misalign();
    br_valid = 1; br_target = 64'h1002;
    cycle();
    br_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
    n_checks++; if (fif.pc !== EXC_V || epc !== 64'h1002 || exc_misalign !== 1'b1) $display("FAIL misalign pc=%h epc=%h mis=%b exp %h/1002/1", fif.pc, epc, exc_misalign, EXC_V); else n_pass++;
`else
    n_checks++; if (fif.pc !== 64'h1000 || exc_misalign !== 1'b0) $display("FAIL misalign pc=%h mis=%b exp 1000/0", fif.pc, exc_misalign); else n_pass++;
`endif
    cycle();
    n_checks++; if (exc_misalign !== 1'b0) $display("FAIL mis_pulse got=%b exp=0", exc_misalign); else n_pass++;
  endtask

  task automatic test_halt();
    logic [63:0] p;
    fif.pc_ready = 1;
    p = fif.pc;
    halt = 1;
    cycle();
    n_checks++; if (fif.pc_valid !== 1'b0 || fif.pc !== p + 64'd4) $display("FAIL halt_enter valid=%b pc=%h exp 0/%h", fif.pc_valid, fif.pc, p + 64'd4); else n_pass++;
    br_valid = 1; br_target = 64'h3000;
    cycle();
    n_checks++; if (fif.pc !== p + 64'd4 || fif.pc_valid !== 1'b0) $display("FAIL halt_br_ignored pc=%h valid=%b exp %h/0", fif.pc, fif.pc_valid, p + 64'd4); else n_pass++;
    br_valid = 0; exc_req = 1; halt = 0;
    cycle();
    n_checks++; if (fif.pc !== EXC_V || fif.pc_valid !== 1'b1 || epc !== p + 64'd4) $display("FAIL halt_exc pc=%h valid=%b epc=%h exp %h/1/%h", fif.pc, fif.pc_valid, epc, EXC_V, p + 64'd4); else n_pass++;
    exc_req = 0;
  endtask

  task automatic test_async_reset();
    br_valid = 1; br_target = 64'h5000;
    #3 rst_n = 0;
    #1;
    n_checks++; if (fif.pc !== RST_V || epc !== 64'd0 || fif.pc_valid !== 1'b0) $display("FAIL async_reset pc=%h epc=%h valid=%b exp %h/0/0", fif.pc, epc, fif.pc_valid, RST_V); else n_pass++;
    clear_inputs();
    cycle();
    rst_n = 1;
    cycle();
    cycle();
    n_checks++; if (fif.pc !== RST_V + 64'd4) $display("FAIL reboot pc=%h exp=%h", fif.pc, RST_V + 64'd4); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      halt         = ($urandom_range(0, 7) == 0);
      exc_req      = ($urandom_range(0, 15) == 0);
      br_valid     = ($urandom_range(0, 5) == 0);
      fif.pc_ready = $urandom_range(0, 1) == 1;
      br_target    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) br_target[1:0] = 2'b00;
      cycle();
      n_checks++; if (fif.pc !== m_pc) $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, fif.pc, m_pc); else n_pass++;
      n_checks++; if (fif.pc_valid !== (!m_boot && !m_halt)) $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, fif.pc_valid, !m_boot && !m_halt); else n_pass++;
      n_checks++; if (epc !== m_epc) $display("FAIL rnd_epc[%0d] got=%h exp=%h", i, epc, m_epc); else n_pass++;
      n_checks++; if (exc_misalign !== m_mis) $display("FAIL rnd_mis[%0d] got=%b exp=%b", i, exc_misalign, m_mis); else n_pass++;
      n_checks++; if (fif.pc_next_seq !== m_pc + STEP) $display("FAIL rnd_nseq[%0d] got=%h exp=%h", i, fif.pc_next_seq, m_pc + STEP); else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    fif.pc_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_branch_vs_exc();
    test_wrap();
    test_misalign();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS64 fetch stage: holds the architectural PC, advances it by a configurable step on each accepted fetch, and redirects it on branch or exception. It generalises the fixed +4 incrementer into a registered, stall-aware unit with a valid/ready handshake toward the instruction cache.

## Interface
- SIZE, 64, PC width in bits
- STEP, 4, increment per accepted fetch (power of two, at most 2^(SIZE-1))
- RESET_VECTOR, 64'hFFFF_FFFF_BFC0_0000, PC loaded on reset, truncated to SIZE
- EXC_VECTOR, 64'hFFFF_FFFF_BFC0_0380, exception redirect target, truncated to SIZE

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  enter HALT; PC held
- br_valid  in  1  branch/jump redirect request
- br_target  in  SIZE  redirect address
- exc_req  in  1  exception redirect request
- pc_ready  in  1  fetch consumer accepts pc this cycle
- pc_valid  out  1  pc is a fetch request
- pc  out  SIZE  current PC
- pc_next_seq  out  SIZE  pc + STEP, combinational, modulo 2^SIZE
- epc  out  SIZE  PC captured on exception
- exc_misalign  out  1  one-cycle pulse: redirect target was misaligned

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT.
- BOOT: pc_valid=0, one cycle, then RUN unconditionally.
- RUN: pc_valid=1. Update priority (highest first): exc_req, br_valid, accept (pc_valid & pc_ready), hold.
  - exc_req: pc←EXC_VECTOR, epc←pc, handshake ignored.
  - br_valid: pc←br_target (subject to Configuration), handshake ignored; the unaccepted pc is dropped.
  - accept: pc←pc+STEP, wrap modulo 2^SIZE (all-ones region wraps to 0, no flag).
  - otherwise pc held.
- halt in RUN → HALT next cycle; the same-cycle redirect/accept still applies.
- HALT: pc_valid=0; pc held; br_valid ignored; exc_req still redirects and exits to RUN; halt deasserted → RUN.
- Misaligned means any of the low log2(STEP) bits of br_target is nonzero.

## Timing
- Reset values: pc=RESET_VECTOR, epc=0, pc_valid=0, exc_misalign=0, state=BOOT; pc_next_seq=RESET_VECTOR+STEP.
- First valid fetch: pc_valid=1 in the second cycle after rst_n deasserts.
- Redirect latency: one cycle; a target presented at edge N is on pc after edge N with pc_valid=1.
- pc is stable while pc_valid=1 and pc_ready=0 unless a redirect occurs.
- exc_req and br_valid in the same cycle: exception wins, branch dropped.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); pending redirect lost.

## Configuration
- PC_ALIGN_CHECK_EN defined: misaligned br_target is not loaded; instead pc←EXC_VECTOR, epc←br_target, exc_misalign pulses 1 for one cycle.
- Undefined: low log2(STEP) bits of br_target forced to 0, loaded as a normal branch; exc_misalign tied to 0.

## Test plan
- Reset/boot: release rst_n, pc_ready=1 → pc=RESET_VECTOR, pc_valid 0 then 1; after 3 accepts pc=RESET_VECTOR+12.
- Backpressure: pc_ready=0 for 5 cycles → pc unchanged, pc_valid=1; pc_ready=1 → pc advances by 4 each cycle.
- Branch vs exception: br_valid=1, target 0x1000, and exc_req=1 in the same cycle with pc=0x2000 → pc=EXC_VECTOR, epc=0x2000; br_valid alone with target 0x1000 → pc=0x1000 next cycle.
- Wrap: SIZE=64, pc set via branch to 64'hFFFF_FFFF_FFFF_FFFC, accept → pc=0, no flag.
- Misaligned target 0x1002: with PC_ALIGN_CHECK_EN → pc=EXC_VECTOR, epc=0x1002, exc_misalign pulse; without → pc=0x1000, exc_misalign=0.
- Halt and mid-run reset: halt=1 → pc_valid=0, branch ignored, exc_req redirects to RUN; rst_n asserted mid-run → pc=RESET_VECTOR without waiting for a clock edge.
